// File: rtl/cardinal_nic_if.sv
// Bus bundle between the cardinal processor / ring router side and the NIC.
// The master modport is the processor+router side; the NIC takes the slave modport.
interface cardinal_nic_if #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 2
);
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] d_in;
   logic [DATA_WIDTH-1:0] d_out;
   logic                  nicEn;
   logic                  nicWrEn;

   logic                  net_si;
   logic                  net_ri;
   logic [DATA_WIDTH-1:0] net_di;
   logic                  net_so;
   logic                  net_ro;
   logic [DATA_WIDTH-1:0] net_do;
   logic                  net_polarity;

   modport master (
      output addr, d_in, nicEn, nicWrEn,
      output net_si, net_di, net_ro, net_polarity,
      input  d_out, net_ri, net_so, net_do
   );

   modport slave (
      input  addr, d_in, nicEn, nicWrEn,
      input  net_si, net_di, net_ro, net_polarity,
      output d_out, net_ri, net_so, net_do
   );
endinterface

// File: rtl/cardinal_nic.sv
// Memory-mapped NIC: single-entry in/out channel buffers with status flags,
// exposed to the processor as four registers and to the ring router as ready/send handshakes.
module cardinal_nic #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 2
) (
   input logic            Clock,
   input logic            Reset,
   cardinal_nic_if.slave  bus
);
   localparam logic [ADDR_WIDTH-1:0] REG_IN_BUF     = ADDR_WIDTH'(0);
   localparam logic [ADDR_WIDTH-1:0] REG_IN_STATUS  = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] REG_OUT_BUF    = ADDR_WIDTH'(2);
   localparam logic [ADDR_WIDTH-1:0] REG_OUT_STATUS = ADDR_WIDTH'(3);

   logic [DATA_WIDTH-1:0] in_buf;
   logic                  in_full;
   logic [DATA_WIDTH-1:0] out_buf;
   logic                  out_full;
   logic                  net_so_q;
   logic [DATA_WIDTH-1:0] net_do_q;

   logic rd_en;
   logic wr_en;
   logic consume;
   logic fill;
   logic out_write;
   logic drain;
   logic vc_bit;

   assign rd_en = bus.nicEn & ~bus.nicWrEn;
   assign wr_en = bus.nicEn & bus.nicWrEn;

   // The VC bit is bit 63 in the processor's [0:63] numbering, i.e. the LSB here.
   assign vc_bit = out_buf[0];

   // All events are qualified by the pre-edge flags, so consume/fill and
   // drain/write are mutually exclusive on any given edge.
   assign consume   = rd_en && (bus.addr == REG_IN_BUF) && in_full;
   assign fill      = bus.net_si && !in_full;
   assign out_write = wr_en && (bus.addr == REG_OUT_BUF) && !out_full;
   assign drain     = out_full && bus.net_ro && (bus.net_polarity == vc_bit);

   always_comb begin
      bus.d_out = '0;
      if (rd_en) begin
         case (bus.addr)
            REG_IN_BUF:     bus.d_out = in_buf;
            REG_IN_STATUS:  bus.d_out = {{(DATA_WIDTH-1){1'b0}}, in_full};
            REG_OUT_BUF:    bus.d_out = out_buf;
            REG_OUT_STATUS: bus.d_out = {{(DATA_WIDTH-1){1'b0}}, out_full};
            default:        bus.d_out = '0;
         endcase
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         in_buf  <= '0;
         in_full <= 1'b0;
      end else if (consume) begin
         in_full <= 1'b0;
      end else if (fill) begin
         in_buf  <= bus.net_di;
         in_full <= 1'b1;
      end
   end

   // net_do keeps the last packet sent; net_so is a one-cycle pulse per packet.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         out_buf  <= '0;
         out_full <= 1'b0;
         net_so_q <= 1'b0;
         net_do_q <= '0;
      end else begin
         net_so_q <= drain;
         if (drain) begin
            net_do_q <= out_buf;
            out_full <= 1'b0;
         end else if (out_write) begin
            out_buf  <= bus.d_in;
            out_full <= 1'b1;
         end
      end
   end

   assign bus.net_ri = ~in_full;
   assign bus.net_so = net_so_q;
   assign bus.net_do = net_do_q;
endmodule

// File: tb/tb_cardinal_nic.sv
// Directed self-checking bench for cardinal_nic: reset, inject/consume,
// backpressure, polarity-gated eject, overwrite guard and drain/write collision.
module tb_cardinal_nic;
   logic Clock;
   logic Reset;
   int   vectors;
   int   miscompares;

   cardinal_nic_if #(.DATA_WIDTH(64), .ADDR_WIDTH(2)) bus ();

   cardinal_nic #(.DATA_WIDTH(64), .ADDR_WIDTH(2)) dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus.slave)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   // Zero-latency register peek that never spans a clock edge, so it never consumes.
   task automatic peek(input logic [1:0] a, output logic [63:0] data);
      bus.addr    = a;
      bus.nicEn   = 1'b1;
      bus.nicWrEn = 1'b0;
      #1;
      data        = bus.d_out;
      bus.nicEn   = 1'b0;
   endtask

   task automatic write_reg(input logic [1:0] a, input logic [63:0] data);
      bus.addr    = a;
      bus.d_in    = data;
      bus.nicEn   = 1'b1;
      bus.nicWrEn = 1'b1;
      step();
      bus.nicEn   = 1'b0;
      bus.nicWrEn = 1'b0;
   endtask

   task automatic test_reset();
      logic [63:0] r;
      Reset = 1'b1;
      step();
      step();
      Reset = 1'b0;
      bus.net_ro = 1'b0;
      write_reg(2'b10, 64'h2);
      peek(2'b11, r);
      vectors++;
      if (r !== 64'h1) begin
         miscompares++;
         $display("[TB] FAIL reset_preload_out_full: got %h expected %h", r, 64'h1);
      end
      // Reset held over a live injection and a would-be drain.
      bus.net_si       = 1'b1;
      bus.net_di       = 64'hFEED_0000_0000_0001;
      bus.net_ro       = 1'b1;
      bus.net_polarity = 1'b0;
      Reset            = 1'b1;
      step();
      step();
      step();
      Reset      = 1'b0;
      bus.net_si = 1'b0;
      bus.net_ro = 1'b0;
      vectors++;
      if (bus.net_so !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_net_so: got %b expected %b", bus.net_so, 1'b0);
      end
      vectors++;
      if (bus.net_ri !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL reset_net_ri: got %b expected %b", bus.net_ri, 1'b1);
      end
      vectors++;
      if (bus.net_do !== 64'h0) begin
         miscompares++;
         $display("[TB] FAIL reset_net_do: got %h expected %h", bus.net_do, 64'h0);
      end
      peek(2'b11, r);
      vectors++;
      if (r !== 64'h0) begin
         miscompares++;
         $display("[TB] FAIL reset_out_status: got %h expected %h", r, 64'h0);
      end
      peek(2'b01, r);
      vectors++;
      if (r !== 64'h0) begin
         miscompares++;
         $display("[TB] FAIL reset_in_status: got %h expected %h", r, 64'h0);
      end
      peek(2'b10, r);
      vectors++;
      if (r !== 64'h0) begin
         miscompares++;
         $display("[TB] FAIL reset_out_buf: got %h expected %h", r, 64'h0);
      end
      peek(2'b00, r);
      vectors++;
      if (r !== 64'h0) begin
         miscompares++;
         $display("[TB] FAIL reset_in_buf: got %h expected %h", r, 64'h0);
      end
   endtask

   task automatic test_inject();
      logic [63:0] r;
      bus.net_si = 1'b1;
      bus.net_di = 64'hDEAD_BEEF_0000_0001;
      step();
      bus.net_si = 1'b0;
      vectors++;
      if (bus.net_ri !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL inject_net_ri: got %b expected %b", bus.net_ri, 1'b0);
      end
      peek(2'b01, r);
      vectors++;
      if (r !== 64'h1) begin
         miscompares++;
         $display("[TB] FAIL inject_in_status: got %h expected %h", r, 64'h1);
      end
      // Consuming read held across one edge.
      bus.addr    = 2'b00;
      bus.nicEn   = 1'b1;
      bus.nicWrEn = 1'b0;
      #1;
      vectors++;
      if (bus.d_out !== 64'hDEAD_BEEF_0000_0001) begin
         miscompares++;
         $display("[TB] FAIL inject_in_buf: got %h expected %h", bus.d_out, 64'hDEAD_BEEF_0000_0001);
      end
      step();
      bus.nicEn = 1'b0;
      peek(2'b01, r);
      vectors++;
      if (r !== 64'h0) begin
         miscompares++;
         $display("[TB] FAIL consume_in_status: got %h expected %h", r, 64'h0);
      end
      vectors++;
      if (bus.net_ri !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL consume_net_ri: got %b expected %b", bus.net_ri, 1'b1);
      end
      // Reading an empty in-buffer returns stale data and keeps the flag clear.
      bus.addr  = 2'b00;
      bus.nicEn = 1'b1;
      #1;
      vectors++;
      if (bus.d_out !== 64'hDEAD_BEEF_0000_0001) begin
         miscompares++;
         $display("[TB] FAIL stale_in_buf: got %h expected %h", bus.d_out, 64'hDEAD_BEEF_0000_0001);
      end
      step();
      bus.nicEn = 1'b0;
      peek(2'b01, r);
      vectors++;
      if (r !== 64'h0) begin
         miscompares++;
         $display("[TB] FAIL stale_in_status: got %h expected %h", r, 64'h0);
      end
   endtask

   task automatic test_backpressure();
      logic [63:0] r;
      bus.net_si = 1'b1;
      bus.net_di = 64'hCAFE;
      step();
      bus.net_di = 64'h1234;
      step();
      step();
      bus.net_si = 1'b0;
      peek(2'b00, r);
      vectors++;
      if (r !== 64'hCAFE) begin
         miscompares++;
         $display("[TB] FAIL backpressure_in_buf: got %h expected %h", r, 64'hCAFE);
      end
      peek(2'b01, r);
      vectors++;
      if (r !== 64'h1) begin
         miscompares++;
         $display("[TB] FAIL backpressure_in_status: got %h expected %h", r, 64'h1);
      end
      vectors++;
      if (bus.net_ri !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL backpressure_net_ri: got %b expected %b", bus.net_ri, 1'b0);
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] r;
      // Consume edge with a new packet offered: pre-edge full, so it is dropped.
      bus.addr    = 2'b00;
      bus.nicEn   = 1'b1;
      bus.nicWrEn = 1'b0;
      bus.net_si  = 1'b1;
      bus.net_di  = 64'h55;
      step();
      bus.nicEn = 1'b0;
      peek(2'b01, r);
      vectors++;
      if (r !== 64'h0) begin
         miscompares++;
         $display("[TB] FAIL b2b_consume_status: got %h expected %h", r, 64'h0);
      end
      step();
      bus.net_si = 1'b0;
      peek(2'b00, r);
      vectors++;
      if (r !== 64'h55) begin
         miscompares++;
         $display("[TB] FAIL b2b_refill_in_buf: got %h expected %h", r, 64'h55);
      end
      peek(2'b01, r);
      vectors++;
      if (r !== 64'h1) begin
         miscompares++;
         $display("[TB] FAIL b2b_refill_status: got %h expected %h", r, 64'h1);
      end
   endtask

   task automatic test_eject_polarity();
      logic [63:0] r;
      bus.net_ro       = 1'b1;
      bus.net_polarity = 1'b0;
      write_reg(2'b10, 64'h0000_0000_0000_00A1);
      step();
      vectors++;
      if (bus.net_so !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL eject_blocked_net_so: got %b expected %b", bus.net_so, 1'b0);
      end
      peek(2'b11, r);
      vectors++;
      if (r !== 64'h1) begin
         miscompares++;
         $display("[TB] FAIL eject_blocked_status: got %h expected %h", r, 64'h1);
      end
      bus.net_polarity = 1'b1;
      step();
      vectors++;
      if (bus.net_so !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL eject_net_so: got %b expected %b", bus.net_so, 1'b1);
      end
      vectors++;
      if (bus.net_do !== 64'hA1) begin
         miscompares++;
         $display("[TB] FAIL eject_net_do: got %h expected %h", bus.net_do, 64'hA1);
      end
      peek(2'b11, r);
      vectors++;
      if (r !== 64'h0) begin
         miscompares++;
         $display("[TB] FAIL eject_status: got %h expected %h", r, 64'h0);
      end
      step();
      vectors++;
      if (bus.net_so !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL eject_pulse_end: got %b expected %b", bus.net_so, 1'b0);
      end
      vectors++;
      if (bus.net_do !== 64'hA1) begin
         miscompares++;
         $display("[TB] FAIL eject_net_do_hold: got %h expected %h", bus.net_do, 64'hA1);
      end
      bus.net_ro = 1'b0;
   endtask

   task automatic test_overwrite_guard();
      logic [63:0] r;
      int          so_seen;
      bus.net_ro = 1'b0;
      write_reg(2'b10, 64'h5);
      bus.addr    = 2'b10;
      bus.d_in    = 64'h7;
      bus.nicEn   = 1'b1;
      bus.nicWrEn = 1'b1;
      #1;
      vectors++;
      if (bus.d_out !== 64'h0) begin
         miscompares++;
         $display("[TB] FAIL write_d_out_zero: got %h expected %h", bus.d_out, 64'h0);
      end
      step();
      bus.nicEn   = 1'b0;
      bus.nicWrEn = 1'b0;
      #1;
      vectors++;
      if (bus.d_out !== 64'h0) begin
         miscompares++;
         $display("[TB] FAIL idle_d_out_zero: got %h expected %h", bus.d_out, 64'h0);
      end
      peek(2'b10, r);
      vectors++;
      if (r !== 64'h5) begin
         miscompares++;
         $display("[TB] FAIL guard_out_buf: got %h expected %h", r, 64'h5);
      end
      so_seen = 0;
      for (int i = 0; i < 10; i++) begin
         bus.net_polarity = i[0];
         step();
         if (bus.net_so === 1'b1) so_seen++;
      end
      vectors++;
      if (so_seen !== 0) begin
         miscompares++;
         $display("[TB] FAIL guard_no_send: got %0d pulses expected %0d", so_seen, 0);
      end
      bus.net_ro       = 1'b1;
      bus.net_polarity = 1'b1;
      step();
      bus.net_ro = 1'b0;
      vectors++;
      if (bus.net_do !== 64'h5 || bus.net_so !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL guard_drain: got so=%b do=%h expected so=1 do=%h", bus.net_so, bus.net_do, 64'h5);
      end
   endtask

   task automatic test_simultaneous();
      logic [63:0] r;
      bus.net_ro = 1'b0;
      write_reg(2'b10, 64'h8);
      bus.net_ro       = 1'b1;
      bus.net_polarity = 1'b0;
      write_reg(2'b10, 64'h9);
      bus.net_ro = 1'b0;
      vectors++;
      if (bus.net_so !== 1'b1 || bus.net_do !== 64'h8) begin
         miscompares++;
         $display("[TB] FAIL collide_drain: got so=%b do=%h expected so=1 do=%h", bus.net_so, bus.net_do, 64'h8);
      end
      peek(2'b11, r);
      vectors++;
      if (r !== 64'h0) begin
         miscompares++;
         $display("[TB] FAIL collide_status: got %h expected %h", r, 64'h0);
      end
      peek(2'b10, r);
      vectors++;
      if (r !== 64'h8) begin
         miscompares++;
         $display("[TB] FAIL collide_out_buf: got %h expected %h", r, 64'h8);
      end
      step();
      peek(2'b11, r);
      vectors++;
      if (r !== 64'h0) begin
         miscompares++;
         $display("[TB] FAIL collide_status_later: got %h expected %h", r, 64'h0);
      end
   endtask

   initial begin
      vectors          = 0;
      miscompares      = 0;
      Reset            = 1'b1;
      bus.addr         = 2'b00;
      bus.d_in         = '0;
      bus.nicEn        = 1'b0;
      bus.nicWrEn      = 1'b0;
      bus.net_si       = 1'b0;
      bus.net_di       = '0;
      bus.net_ro       = 1'b0;
      bus.net_polarity = 1'b0;
      test_reset();
      test_inject();
      test_backpressure();
      test_back_to_back();
      test_eject_polarity();
      test_overwrite_guard();
      test_simultaneous();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end
endmodule

// File: doc/cardinal_nic.md
Name: cardinal_nic

Overview:
- Memory-mapped network interface controller; sits directly downstream of the cardinal processor's data-memory port, in parallel with dmem.
- Consumes processor loads/stores decoded to the NIC region.
- Each direction has a single-entry channel buffer with a status flag.
- Provides a one-word-per-transfer ready/send handshake to the ring router.

Parameters:
- DATA_WIDTH, 64, packet/data word width.
- ADDR_WIDTH, 2, register-select width.

Ports:
- Clock  input  1  system clock, all state updates on posedge.
- Reset  input  1  synchronous, active-high.
- addr  input  2  register select: 00 in-buffer, 01 in-status, 10 out-buffer, 11 out-status.
- d_in  input  64  store data from processor.
- d_out  output  64  load data to processor.
- nicEn  input  1  access enable.
- nicWrEn  input  1  write enable, qualified by nicEn.
- net_si  input  1  router send-in valid.
- net_ri  output  1  NIC ready to accept from router.
- net_di  input  64  packet from router.
- net_so  output  1  NIC send-out valid.
- net_ro  input  1  router ready to accept.
- net_do  output  64  packet to router.
- net_polarity  input  1  router phase; injection permitted only when net_polarity == out_buf bit 63 (VC bit, LSB in [0:63] ordering).

Behaviour:
- Reset clears in_buf=0, in_full=0, out_buf=0, out_full=0, net_so=0, net_do=0. Reset overrides every other event in the same edge, including a mid-transfer handshake.
- Processor reads (nicEn=1, nicWrEn=0) are combinational, zero latency:
  - addr 00 → in_buf.
  - addr 01 → {63'b0, in_full}.
  - addr 10 → out_buf.
  - addr 11 → {63'b0, out_full}.
- d_out=0 when nicEn=0 or nicWrEn=1.
- Read-consume: a read of addr 00 with in_full=1 clears in_full at that posedge. A read of addr 00 with in_full=0 returns stale in_buf and leaves the flag 0.
- Processor writes (nicEn=1, nicWrEn=1):
  - addr 10 with out_full=0: out_buf<=d_in, out_full<=1.
  - addr 10 with out_full=1: ignored, no overwrite.
  - Writes to 00/01/11: ignored.
- Network input:
  - net_ri = ~in_full, combinational from the register.
  - At posedge with net_si=1 and net_ri=1: in_buf<=net_di, in_full<=1.
  - net_si while net_ri=0: ignored, data dropped; the router is responsible for holding it.
  - Consume and network fill cannot coincide (fill requires empty, consume requires full). The flag is evaluated from the pre-edge value.
- Network output, registered:
  - At posedge, if out_full=1, net_ro=1 and net_polarity==out_buf[63]: net_so<=1, net_do<=out_buf, out_full<=0.
  - Otherwise net_so<=0 and net_do holds its previous value.
  - net_so is therefore a one-cycle pulse per packet, asserted the cycle after the condition.
- Simultaneous drain and processor write of addr 10 at the same edge: the write is ignored because the pre-edge out_full=1. The processor re-polls addr 11.
- Throughput: at most one packet per 2 cycles per direction (fill/consume round-trip through the flag).
- No FIFO depth beyond 1. No interrupts. Status flags are the only flow-control signals visible to software.

Test Plan:
- Reset: assert Reset 3 cycles mid-injection with out_full=1, then release → net_so=0, net_ri=1, addr 11 reads 64'h0, addr 01 reads 64'h0.
- Inject: net_si=1, net_di=64'hDEAD_BEEF_0000_0001 for one cycle → net_ri=0 next cycle; addr 01 reads 64'h1; addr 00 reads DEAD_BEEF_0000_0001; after that read edge addr 01 reads 64'h0 and net_ri=1.
- Backpressure in: in_full=1, net_si=1 with net_di=64'h1234 → in_buf unchanged, in_full stays 1.
- Eject with polarity:
  - Write addr 10 = 64'h0000_0000_0000_00A1 (bit63=1) with net_ro=1, net_polarity=0 → net_so stays 0, addr 11 reads 64'h1.
  - Toggle net_polarity=1 → single-cycle net_so=1, net_do=64'hA1, addr 11 reads 64'h0 after.
- Output overwrite guard: out_full=1 holding 64'h5, write addr 10 = 64'h7 → out_buf stays 5; with net_ro=0 held 10 cycles, net_so never asserts.
- Simultaneous drain+write: at the drain edge, write addr 10 = 64'h9 → net_do=old value, out_full=0 afterward, 64'h9 not captured.
